trace_sched: RTL
================

TRACE_SCHED -- requirements
Module: trace_sched

Interface
REQ-001 Parameter DW, default 8, width of every trace data field.
REQ-002 Parameter TW, default 16, width of the free-running timestamp.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 dsp_valid  input  1  display request present.
REQ-006 dsp_data  input  DW  display payload.
REQ-007 dsp_ready  output  1  display request accepted this cycle when high with dsp_valid.
REQ-008 str_valid  input  1  strobe request present.
REQ-009 str_data  input  DW  strobe payload, sampled at acceptance.
REQ-010 str_ready  output  1  strobe buffer empty; accepts when high with str_valid.
REQ-011 mon_en  input  1  monitor channel enable.
REQ-012 mon_data  input  DW  continuously watched monitor value.
REQ-013 out_valid  output  1  trace record present.
REQ-014 out_ready  input  1  sink accepts record when high with out_valid.
REQ-015 out_src  output  2  record source: 0 display, 1 strobe, 2 monitor; 3 never driven.
REQ-016 out_data  output  DW  record payload.
REQ-017 out_time  output  TW  record timestamp.

Function
REQ-018 Timestamp counter SHALL increment by 1 every cycle, wrapping from 2^TW-1 to 0.
REQ-019 Output register SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 Output register SHALL load when EMPTY, or when FULL with out_ready=1, and a source is eligible; otherwise EMPTY after drain.
REQ-021 Load priority SHALL be display > strobe buffer > monitor pending, fixed, no fairness; monitor starvation under continuous display is permitted.
REQ-022 dsp_ready SHALL equal the load condition (EMPTY or out_ready=1), independent of dsp_valid; display payload goes straight to the output register with out_time = counter at load.
REQ-023 Strobe buffer SHALL hold one entry; accept captures str_data and counter value; entry loads to output no earlier than the next cycle (minimum latency 2 cycles) and only when dsp_valid=0.
REQ-024 Monitor SHALL set pending, record mon_data and counter value when mon_en=1 and mon_data differs from the last recorded value.
REQ-025 First cycle with mon_en=1 after mon_en=0 or reset SHALL set pending unconditionally with current mon_data.
REQ-026 A new monitor change while pending SHALL overwrite data and time (latest value wins); no queueing.
REQ-027 mon_en=0 SHALL clear monitor pending and suppress detection.
REQ-028 While FULL and out_ready=0, out_valid, out_src, out_data, out_time SHALL hold stable.
REQ-029 Simultaneous drain and load SHALL produce back-to-back records with no bubble.
REQ-030 Monitor change in the same cycle its pending entry is loaded SHALL re-arm pending with the new value.

Reset
REQ-031 With rst=1 at a clock edge: counter=0, out_valid=0, out_src=0, out_data=0, out_time=0, strobe buffer empty, monitor pending=0, monitor armed=0, last monitor value=0.
REQ-032 dsp_ready and str_ready SHALL be 0 during reset cycles and 1 on the first cycle after rst deasserts.
REQ-033 Reset mid-operation SHALL discard all held and pending records; none emitted afterwards.

Verification
REQ-034 dsp_valid=1, str_valid=1 same cycle, out_ready=1 -> display record src 0 first, strobe record src 1 next cycle, strobe out_time = acceptance cycle.
REQ-035 out_ready=0 for 5 cycles with record FULL -> outputs stable, dsp_ready=0, str_ready=0 after buffer fills; release -> drain in priority order, no loss.
REQ-036 mon_en rises with mon_data=8'h00, then 8'h01, 8'h02 on consecutive cycles under display stall -> single monitor record 8'h02 with its change time.
REQ-037 Counter at 16'hFFFF on display load -> out_time=16'hFFFF; next load out_time=16'h0000.
REQ-038 rst pulsed with strobe buffered, monitor pending, record FULL -> out_valid=0 next cycle, no stale record ever appears.

Source files
------------

// File: rtl/trace_sched.sv
// Trace scheduler: merges display, strobe and monitor events into a single
// timestamped record stream behind a one-entry output register.
module trace_sched #(
    parameter int unsigned DW = 8,
    parameter int unsigned TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dsp_valid,
    input  logic [DW-1:0] dsp_data,
    output logic          dsp_ready,
    input  logic          str_valid,
    input  logic [DW-1:0] str_data,
    output logic          str_ready,
    input  logic          mon_en,
    input  logic [DW-1:0] mon_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_src,
    output logic [DW-1:0] out_data,
    output logic [TW-1:0] out_time
);

    localparam logic [1:0] SRC_DSP = 2'd0;
    localparam logic [1:0] SRC_STR = 2'd1;
    localparam logic [1:0] SRC_MON = 2'd2;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] cnt;

    logic          load_ok, ld_dsp, ld_str, ld_mon;
    logic          str_full;
    logic [DW-1:0] str_buf_data;
    logic [TW-1:0] str_buf_time;
    logic          str_acc;

    logic          mon_armed, mon_pend, mon_hit;
    logic [DW-1:0] mon_last, mon_pdata;
    logic [TW-1:0] mon_ptime;

    // Free-running timestamp
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

    // Load arbitration: display > strobe buffer > monitor pending
    always_comb begin
        state_nx  = state;
        load_ok   = (state == EMPTY) || out_ready;
        ld_dsp    = load_ok && dsp_valid;
        ld_str    = load_ok && !dsp_valid && str_full;
        ld_mon    = load_ok && !dsp_valid && !str_full && mon_pend && mon_en;
        dsp_ready = load_ok && !rst;
        str_ready = !str_full && !rst;
        str_acc   = str_valid && str_ready;
        mon_hit   = mon_en && (!mon_armed || (mon_data != mon_last));
        if (ld_dsp || ld_str || ld_mon) begin
            state_nx = FULL;
        end else if (state == FULL && out_ready) begin
            state_nx = EMPTY;
        end
    end

    assign out_valid = (state == FULL);

    // Output record; untouched while stalled so fields hold stable
    always_ff @(posedge clk) begin
        if (rst) begin
            out_src  <= SRC_DSP;
            out_data <= '0;
            out_time <= '0;
        end else if (ld_dsp) begin
            out_src  <= SRC_DSP;
            out_data <= dsp_data;
            out_time <= cnt;
        end else if (ld_str) begin
            out_src  <= SRC_STR;
            out_data <= str_buf_data;
            out_time <= str_buf_time;
        end else if (ld_mon) begin
            out_src  <= SRC_MON;
            out_data <= mon_pdata;
            out_time <= mon_ptime;
        end
    end

    // One-entry strobe buffer; accept and drain are mutually exclusive
    always_ff @(posedge clk) begin
        if (rst) begin
            str_full     <= 1'b0;
            str_buf_data <= '0;
            str_buf_time <= '0;
        end else if (str_acc) begin
            str_full     <= 1'b1;
            str_buf_data <= str_data;
            str_buf_time <= cnt;
        end else if (ld_str) begin
            str_full     <= 1'b0;
        end
    end

    // Change detector: a new change wins over a same-cycle drain of pending
    always_ff @(posedge clk) begin
        if (rst) begin
            mon_armed <= 1'b0;
            mon_pend  <= 1'b0;
            mon_last  <= '0;
            mon_pdata <= '0;
            mon_ptime <= '0;
        end else if (!mon_en) begin
            mon_armed <= 1'b0;
            mon_pend  <= 1'b0;
        end else begin
            mon_armed <= 1'b1;
            if (mon_hit) begin
                mon_pend  <= 1'b1;
                mon_last  <= mon_data;
                mon_pdata <= mon_data;
                mon_ptime <= cnt;
            end else if (ld_mon) begin
                mon_pend  <= 1'b0;
            end
        end
    end

endmodule
